// File: rtl/glyph_row_scheduler_pkg.sv
// Shared glyph geometry, field widths and burst FSM encoding for the digit
// glyph ROM scheduler and the blocks that draw from the same ROM.
package glyph_row_scheduler_pkg;

    localparam int GLYPH_W      = 20;
    localparam int GLYPH_H      = 20;
    localparam int GLYPH_PIXELS = GLYPH_W * GLYPH_H;
    localparam int ROW_W        = 5;
    localparam int COL_W        = 5;
    localparam int OWN_W        = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_t;

    // Sideband that travels one stage behind the ROM address.
    typedef struct packed {
        logic             valid;
        logic [COL_W-1:0] col;
        logic [OWN_W-1:0] owner;
        logic             done;
    } pix_tag_t;

endpackage

// File: rtl/glyph_row_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N.
module rr_arbiter
    import glyph_row_scheduler_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [OWN_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic [OWN_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        win = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                win[j] = 1'b1;
                idx    = OWN_W'(j);
            end
        end
    end

endmodule

// File: rtl/glyph_row_scheduler.sv
// Shares the single-port glyph ROM among NUM_REQ requesters; each grant
// streams one glyph row as GLYPH_W back-to-back reads tagged with col/owner.
module glyph_row_scheduler
    import glyph_row_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GLYPH_W = glyph_row_scheduler_pkg::GLYPH_W,
    parameter int GLYPH_H = glyph_row_scheduler_pkg::GLYPH_H,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8
) (
    input  logic                     i_clk2,
    input  logic                     i_rst_n,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*ROW_W-1:0] i_row,
    output logic [NUM_REQ-1:0]       o_gnt,
    output logic                     o_err,
    output logic                     o_busy,
    output logic [ADDR_W-1:0]        o_rom_addr,
    input  logic [DATA_W-1:0]        i_rom_data,
    output logic [DATA_W-1:0]        o_pix_data,
    output logic                     o_pix_valid,
    output logic [COL_W-1:0]         o_pix_col,
    output logic [OWN_W-1:0]         o_pix_owner,
    output logic                     o_row_done
);

    burst_state_t       state;
    logic [COL_W-1:0]   col;
    logic [ADDR_W-1:0]  base;
    logic [OWN_W-1:0]   owner;
    logic [OWN_W-1:0]   rr_ptr;
    pix_tag_t           tag_q;

    logic [NUM_REQ-1:0] win;
    logic [OWN_W-1:0]   win_idx;
    logic               win_any;
    logic               last_col;
    logic               arb_en;
    logic               row_ok;
    logic [ROW_W-1:0]   sel_row;
    logic [ADDR_W-1:0]  row_ext;
    logic [ADDR_W-1:0]  base_nxt;
    logic [OWN_W-1:0]   ptr_nxt;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req (i_req),
        .ptr (rr_ptr),
        .win (win),
        .idx (win_idx),
        .any (win_any)
    );

    assign last_col = (col == COL_W'(GLYPH_W - 1));
    // Re-arbitrate while issuing the last column so bursts chain with no bubble.
    assign arb_en   = (state == IDLE) || last_col;
    assign sel_row  = i_row[ROW_W*win_idx +: ROW_W];
    assign row_ok   = (int'(sel_row) < GLYPH_H);
    assign row_ext  = ADDR_W'(sel_row);
    assign ptr_nxt  = (win_idx == OWN_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    generate
        if (GLYPH_W == 20) begin : g_base_shift
            assign base_nxt = (row_ext << 4) + (row_ext << 2);
        end else begin : g_base_mul
            assign base_nxt = ADDR_W'(int'(sel_row) * GLYPH_W);
        end
    endgenerate

    always_ff @(posedge i_clk2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            col        <= '0;
            base       <= '0;
            owner      <= '0;
            rr_ptr     <= '0;
            o_gnt      <= '0;
            o_err      <= 1'b0;
            o_rom_addr <= '0;
            tag_q      <= '0;
        end else begin
            o_gnt       <= '0;
            o_err       <= 1'b0;
            tag_q.valid <= (state == BURST);
            tag_q.col   <= col;
            tag_q.owner <= owner;
            tag_q.done  <= (state == BURST) && last_col;
            if (arb_en) begin
                if (win_any) begin
                    o_gnt  <= win;
                    owner  <= win_idx;
                    rr_ptr <= ptr_nxt;
                    if (row_ok) begin
                        state      <= BURST;
                        col        <= '0;
                        base       <= base_nxt;
                        o_rom_addr <= base_nxt;
                    end else begin
                        state <= IDLE;
                        o_err <= 1'b1;
                    end
                end else begin
                    state <= IDLE;
                end
            end else begin
                col        <= col + 1'b1;
                o_rom_addr <= base + ADDR_W'(col + 1'b1);
            end
        end
    end

    assign o_busy      = (state == BURST);
    assign o_pix_data  = i_rom_data;
    assign o_pix_valid = tag_q.valid;
    assign o_pix_col   = tag_q.col;
    assign o_pix_owner = tag_q.owner;
    assign o_row_done  = tag_q.done;

endmodule

// File: tb/tb_glyph_row_scheduler.sv
// Scoreboard bench: a transaction-level model predicts grants and pixels with
// cycle stamps; a negedge monitor pops and compares against the DUT.
module tb_glyph_row_scheduler;

    localparam int NR = 4;
    localparam int GW = 20;
    localparam int GH = 20;

    logic            i_clk2 = 1'b0;
    logic            i_rst_n = 1'b0;
    logic [NR-1:0]   i_req = '0;
    logic [NR*5-1:0] i_row = '0;
    logic [NR-1:0]   o_gnt;
    logic            o_err, o_busy, o_pix_valid, o_row_done;
    logic [9:0]      o_rom_addr;
    logic [7:0]      i_rom_data, o_pix_data;
    logic [4:0]      o_pix_col;
    logic [2:0]      o_pix_owner;

    typedef struct { int cyc; int w; bit err; } gnt_exp_t;
    typedef struct { int cyc; logic [7:0] data; int col; int owner; bit done; } pix_exp_t;

    gnt_exp_t     gq[$];
    pix_exp_t     pq[$];
    logic [7:0]   rom [400];
    int           n_tests = 0, n_fail = 0, edge_cnt = 0;
    int           m_ptr = 0, m_left = 0, m_base = 0, m_w = 0, m_row = 0;
    bit           m_busy = 1'b0;
    bit           rand_en = 1'b0;
    bit           found;
    logic [NR-1:0] refire = '0, pend_refire = '0;

    glyph_row_scheduler dut (
        .i_clk2      (i_clk2),
        .i_rst_n     (i_rst_n),
        .i_req       (i_req),
        .i_row       (i_row),
        .o_gnt       (o_gnt),
        .o_err       (o_err),
        .o_busy      (o_busy),
        .o_rom_addr  (o_rom_addr),
        .i_rom_data  (i_rom_data),
        .o_pix_data  (o_pix_data),
        .o_pix_valid (o_pix_valid),
        .o_pix_col   (o_pix_col),
        .o_pix_owner (o_pix_owner),
        .o_row_done  (o_row_done)
    );

    always #5 i_clk2 = ~i_clk2;

    // External ROM: one-cycle registered read.
    always @(posedge i_clk2)
        i_rom_data <= (o_rom_addr < 10'd400) ? rom[o_rom_addr] : 8'h00;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_cnt, act, exp);
        end
    endtask

    // Reference model: arbitration points are idle cycles or the last address
    // cycle of a burst; m_left counts address cycles still to issue.
    always @(posedge i_clk2) begin
        edge_cnt++;
        if (!i_rst_n) begin
            m_ptr  = 0;
            m_left = 0;
        end else if (m_left <= 1) begin
            m_w = -1;
            for (int k = 0; k < NR; k++)
                if (m_w < 0 && i_req[(m_ptr + k) % NR]) m_w = (m_ptr + k) % NR;
            if (m_w < 0) begin
                m_left = 0;
            end else begin
                m_row = int'(i_row[5*m_w +: 5]);
                gq.push_back('{edge_cnt, m_w, m_row >= GH});
                m_ptr = (m_w + 1) % NR;
                if (m_row >= GH) begin
                    m_left = 0;
                end else begin
                    m_left = GW;
                    m_base = m_row * GW;
                    for (int c = 0; c < GW; c++)
                        pq.push_back('{edge_cnt + 1 + c, rom[m_base + c], c, m_w, c == GW - 1});
                end
            end
        end else begin
            m_left--;
        end
        m_busy = (m_left > 0);
    end

    always @(negedge i_clk2) begin
        if (!i_rst_n) begin
            chk("rst_outs", {o_gnt, o_err, o_busy, o_rom_addr, o_pix_valid,
                             o_pix_col, o_pix_owner, o_row_done}, '0);
            gq.delete();
            pq.delete();
        end else begin
            chk("busy", o_busy, m_busy);
            if (m_busy) chk("rom_addr", o_rom_addr, m_base + GW - m_left);
            if (gq.size() > 0 && gq[0].cyc == edge_cnt) begin
                chk("gnt", o_gnt, 1 << gq[0].w);
                chk("err", o_err, gq[0].err);
                void'(gq.pop_front());
            end else begin
                chk("gnt_unexp", {o_gnt, o_err}, '0);
            end
            if (pq.size() > 0 && pq[0].cyc == edge_cnt) begin
                chk("pix_valid", o_pix_valid, 1);
                chk("pix_col", o_pix_col, pq[0].col);
                chk("pix_owner", o_pix_owner, pq[0].owner);
                chk("row_done", o_row_done, pq[0].done);
                chk("pix_data", o_pix_data, pq[0].data);
                void'(pq.pop_front());
            end else begin
                chk("pix_unexp", {o_pix_valid, o_row_done}, '0);
            end
        end
    end

    function automatic logic [4:0] pick_row();
        if ($urandom_range(0, 9) == 0) return 5'($urandom_range(20, 31));
        return 5'($urandom_range(0, 19));
    endfunction

    // Requesters drop i_req in the grant cycle; refire re-raises next cycle.
    task automatic step();
        @(posedge i_clk2);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (o_gnt[i]) begin
                i_req[i]       = 1'b0;
                pend_refire[i] = refire[i];
            end else if (pend_refire[i]) begin
                i_req[i]       = 1'b1;
                pend_refire[i] = 1'b0;
            end else if (rand_en && !i_req[i] && $urandom_range(0, 99) < 15) begin
                i_req[i]       = 1'b1;
                i_row[5*i +: 5] = pick_row();
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic set_req(input int i, input int r);
        i_row[5*i +: 5] = 5'(r);
        i_req[i]        = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (gq.size() > 0 || pq.size() > 0 || o_busy || i_req != 0); i++)
            step();
        chk("drain_gnt_q", gq.size(), 0);
        chk("drain_pix_q", pq.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 400; i++) rom[i] = 8'($urandom);
        run(3);
        i_rst_n = 1'b1;
        run(2);

        set_req(2, 3);                              // single request, addr 60..79
        run(30);
        for (int i = 0; i < NR; i++) set_req(i, $urandom_range(0, 19));
        run(90);                                    // contention, 80 pixels back-to-back

        refire = 4'b0001;                           // fairness: 0 re-requests at once
        set_req(0, 7);
        set_req(1, 8);
        run(45);
        refire = '0;
        drain();

        set_req(0, 20);                             // bad row, then pending request
        set_req(1, 4);
        run(30);
        set_req(3, 19);                             // boundary address 380..399
        run(30);

        rand_en = 1'b1;
        run(1500);
        rand_en = 1'b0;
        drain();

        set_req(1, 5);                              // reset at col 7 of row 5
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            found = o_busy && (o_rom_addr == 10'd107);
        end
        chk("reach_col7", found, 1);
        i_rst_n     = 1'b0;
        i_req       = '0;
        pend_refire = '0;
        run(2);
        i_rst_n = 1'b1;
        run(5);
        set_req(0, 1);                              // rr_ptr back at 0: 0 wins over 3
        set_req(3, 2);
        run(50);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
